// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU among NREQ requesters using a round-robin grant.
// The winner's op/operands are latched into registers that drive the ALU. The
// ALU's result and Zero flag are captured one cycle later. They are then held
// on a single valid/ready response channel until the consumer takes them.
// Optional feature macro: ALU_ARB_STATS_EN adds the grant_cnt output, which
// holds one saturating 16-bit accept counter per requester.
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int OPW  = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OPW-1:0]  req_op,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    output logic [OPW-1:0]       alu_op,
    output logic [DW-1:0]        alu_a,
    output logic [DW-1:0]        alu_b,
    input  logic [DW-1:0]        alu_result,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_result,
    output logic                 rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   grant_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_last_grant;
    logic [IDW-1:0]     r_rsp_id;
    logic [OPW-1:0]     r_alu_op;
    logic [DW-1:0]      r_alu_a;
    logic [DW-1:0]      r_alu_b;
    logic [DW-1:0]      r_rsp_result;
    logic               r_rsp_valid;
    logic               r_rsp_zero;

    logic [2*NREQ-1:0]  w_valid2;
    logic [2*NREQ-1:0]  w_rot_full;
    logic [2*NREQ-1:0]  w_gnt2;
    logic [IDW:0]       w_shamt;
    logic [NREQ-1:0]    w_rot;
    logic [NREQ-1:0]    w_first;
    logic [NREQ-1:0]    w_onehot;
    logic               w_any;
    logic               w_accept;
    logic [IDW-1:0]     w_grant;
    logic [OPW-1:0]     w_sel_op;
    logic [DW-1:0]      w_sel_a;
    logic [DW-1:0]      w_sel_b;

    logic [OPW-1:0]     w_op [NREQ];
    logic [DW-1:0]      w_a  [NREQ];
    logic [DW-1:0]      w_b  [NREQ];

    // Unpack the flat requester buses into per-requester fields.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_op[gi] = req_op[gi*OPW +: OPW];
            assign w_a[gi]  = req_a[gi*DW +: DW];
            assign w_b[gi]  = req_b[gi*DW +: DW];
        end
    endgenerate

    // Round-robin search: rotate the valids so that last_grant+1 lands at bit 0.
    // Then take the lowest set bit, and rotate that one-hot back into place.
    // The valid vector is doubled so that a plain right shift acts as a rotation.
    assign w_valid2   = {req_valid, req_valid};
    assign w_shamt    = {1'b0, r_last_grant} + (IDW+1)'(1);
    assign w_rot_full = w_valid2 >> w_shamt;
    assign w_rot      = w_rot_full[NREQ-1:0];
    assign w_first    = w_rot & (~w_rot + NREQ'(1));
    assign w_gnt2     = {{NREQ{1'b0}}, w_first} << w_shamt;
    assign w_onehot   = w_gnt2[2*NREQ-1:NREQ] | w_gnt2[NREQ-1:0];
    assign w_any      = |req_valid;

    // Grants are only issued from IDLE, and never while reset is being applied.
    assign w_accept  = (r_state == S_IDLE) && reset && w_any;
    assign req_ready = w_accept ? w_onehot : '0;

    // Encode the one-hot winner and select its op/operands.
    always_comb begin
        w_grant  = '0;
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_onehot[i]) begin
                w_grant  = IDW'(i);
                w_sel_op = w_op[i];
                w_sel_a  = w_a[i];
                w_sel_b  = w_b[i];
            end
        end
    end

    // Main sequencer: IDLE latches the winner, EXEC captures the ALU, RESP waits for the consumer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= IDW'(NREQ - 1);
            r_rsp_id     <= '0;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_result <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_op     <= w_sel_op;
                        r_alu_a      <= w_sel_a;
                        r_alu_b      <= w_sel_b;
                        r_last_grant <= w_grant;
                        r_rsp_id     <= w_grant;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_result <= alu_result;
                    r_rsp_zero   <= alu_zero;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_grant_cnt [NREQ];

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_stats
            // Count accepts of this requester, sticking at all-ones.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_grant_cnt[gi] <= '0;
                end else if (req_ready[gi] && (r_grant_cnt[gi] != 16'hFFFF)) begin
                    r_grant_cnt[gi] <= r_grant_cnt[gi] + 16'd1;
                end
            end
            assign grant_cnt[gi*16 +: 16] = r_grant_cnt[gi];
        end
    endgenerate
`else
    // Statistics disabled: no counters and no grant_cnt port.
`endif

endmodule
